// File: rtl/fp_addsub_arbiter_if.sv
// Request/response bundle between N_REQ requesters, the consumer and the shared FP add/sub block.
// Ports: req_valid/req_ready/req_a/req_b/req_sub per requester (operands packed 32 bits each),
//        rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_exception shared response bus.
interface fp_addsub_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_sub;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_exception;

  // requesters + response consumer
  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_exception
  );

  // shared add/sub block
  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_exception
  );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Round-robin shares one IEEE-754 single add/sub unit (RNE, denormals flushed to zero) among N_REQ requesters.
// Latency: grant at edge k -> rsp_valid after edge k+1; one op per cycle, at most 2 in flight.
// Backpressure: rsp_ready low freezes S2; S1 and the arbiter stall only when both stages are full.
// Ports: CLK, RESETn (async active-low), bus (slave side of fp_addsub_arbiter_if),
//        ops_done = wrapping count of accepted responses.
module fp_addsub_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  fp_addsub_arbiter_if.slave   bus,
  output logic [15:0]          ops_done
);

  logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d, rr_ptr_q, rr_ptr_d;
  logic [31:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_result_q, s2_result_d;
  logic            s1_sub_q, s1_sub_d, s2_exc_q, s2_exc_d;
  logic [15:0]     ops_done_q, ops_done_d;

  logic            s2_adv, s1_adv, s1_free, gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic [N_REQ-1:0] grant;

  assign s2_adv  = !s2_valid_q | bus.rsp_ready;
  assign s1_adv  = s1_valid_q & s2_adv;
  assign s1_free = !s1_valid_q | s2_adv;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_vld && s1_free && bus.req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  // rr_ptr resets to 0 and S1 is free in reset, so the grant must be masked explicitly
  assign bus.req_ready = grant & {N_REQ{RESETn}};

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  // add/sub datapath: x is the larger magnitude, y is aligned with guard/round/sticky bits
  logic              fa_swap, fa_sx, fa_sy, fa_exc;
  logic [7:0]        fa_ex, fa_ey, fa_d;
  logic [23:0]       fa_mx, fa_my;
  logic [53:0]       fa_wide;
  logic [26:0]       fa_al, fa_norm;
  logic [27:0]       fa_sum;
  logic [4:0]        fa_lz;
  logic [24:0]       fa_man;
  logic signed [9:0] fa_exp_n, fa_exp_r;
  logic [31:0]       fa_res;

  always_comb begin
    fa_exc  = (s1_a_q[30:23] == 8'hFF) || (s1_b_q[30:23] == 8'hFF);
    fa_swap = s1_b_q[30:0] > s1_a_q[30:0];
    fa_sx   = fa_swap ? (s1_b_q[31] ^ s1_sub_q) : s1_a_q[31];
    fa_sy   = fa_swap ? s1_a_q[31] : (s1_b_q[31] ^ s1_sub_q);
    fa_ex   = fa_swap ? s1_b_q[30:23] : s1_a_q[30:23];
    fa_ey   = fa_swap ? s1_a_q[30:23] : s1_b_q[30:23];
    fa_mx   = (fa_ex == 8'd0) ? 24'd0 : {1'b1, fa_swap ? s1_b_q[22:0] : s1_a_q[22:0]};
    fa_my   = (fa_ey == 8'd0) ? 24'd0 : {1'b1, fa_swap ? s1_a_q[22:0] : s1_b_q[22:0]};
    fa_d    = fa_ex - fa_ey;
    fa_wide = {fa_my, 30'd0} >> fa_d;
    // beyond 26 positions y only contributes to sticky
    if (fa_d > 8'd26) fa_al = {26'd0, |fa_my};
    else              fa_al = {fa_wide[53:28], |fa_wide[27:0]};
    if (fa_sx ^ fa_sy) fa_sum = {1'b0, fa_mx, 3'b000} - {1'b0, fa_al};
    else               fa_sum = {1'b0, fa_mx, 3'b000} + {1'b0, fa_al};
    fa_lz = lzc27(fa_sum[26:0]);
    if (fa_sum[27]) begin
      fa_norm  = {fa_sum[27:2], |fa_sum[1:0]};
      fa_exp_n = $signed({2'b00, fa_ex}) + 10'sd1;
    end else begin
      fa_norm  = fa_sum[26:0] << fa_lz;
      fa_exp_n = $signed({2'b00, fa_ex}) - $signed({5'b00000, fa_lz});
    end
    // round to nearest even on guard bit, round|sticky, and lsb
    fa_man   = {1'b0, fa_norm[26:3]} + {24'd0, fa_norm[2] & (fa_norm[3] | (|fa_norm[1:0]))};
    fa_exp_r = fa_exp_n + ((fa_man[24:23] == 2'b10) ? 10'sd1 : 10'sd0);
    if (fa_exc)                    fa_res = 32'd0;
    else if (fa_sum == 28'd0)      fa_res = {fa_sx & fa_sy, 31'd0};
    else if (fa_exp_r <= 10'sd0)   fa_res = {fa_sx, 31'd0};
    else if (fa_exp_r >= 10'sd255) fa_res = {fa_sx, 8'hFF, 23'd0};
    else                           fa_res = {fa_sx, fa_exp_r[7:0], fa_man[22:0]};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_sub_d    = s1_sub_q;
    rr_ptr_d    = rr_ptr_q;
    s2_valid_d  = s2_valid_q;
    s2_id_d     = s2_id_q;
    s2_result_d = s2_result_q;
    s2_exc_d    = s2_exc_q;
    ops_done_d  = ops_done_q;
    if (gnt_vld) begin
      s1_valid_d = 1'b1;
      s1_id_d    = gnt_idx;
      s1_a_d     = bus.req_a[32*gnt_idx +: 32];
      s1_b_d     = bus.req_b[32*gnt_idx +: 32];
      s1_sub_d   = bus.req_sub[gnt_idx];
      rr_ptr_d   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv) begin
      s2_valid_d  = 1'b1;
      s2_id_d     = s1_id_q;
      s2_result_d = fa_res;
      s2_exc_d    = fa_exc;
    end else if (s2_adv) begin
      s2_valid_d = 1'b0;
    end
    if (s2_valid_q && bus.rsp_ready) ops_done_d = ops_done_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sub_q    <= 1'b0;
      rr_ptr_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
      s2_result_q <= '0;
      s2_exc_q    <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sub_q    <= s1_sub_d;
      rr_ptr_q    <= rr_ptr_d;
      s2_valid_q  <= s2_valid_d;
      s2_id_q     <= s2_id_d;
      s2_result_q <= s2_result_d;
      s2_exc_q    <= s2_exc_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign bus.rsp_valid     = s2_valid_q;
  assign bus.rsp_id        = s2_id_q;
  assign bus.rsp_result    = s2_result_q;
  assign bus.rsp_exception = s2_exc_q;
  assign ops_done          = ops_done_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against an exact-arithmetic FP model and an in-flight queue model.
// Ports: drives the master side of fp_addsub_arbiter_if, CLK and RESETn.
module tb_fp_addsub_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [15:0] ops_done;

  fp_addsub_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();

  fp_addsub_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .bus      (bus),
    .ops_done (ops_done)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Exact reference: operands become integers on a common scale, summed exactly, then rounded to nearest even.
  function automatic logic [32:0] ref_addsub(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic   sa, sb, neg;
    int     ea, eb, emin, p, k, e;
    longint ma, mb, va, vb, sum, mag, q, rem, half;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'd0};
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 64'sd0 : (longint'(a[22:0]) + (64'sd1 << 23));
    mb = (eb == 0) ? 64'sd0 : (longint'(b[22:0]) + (64'sd1 << 23));
    if (ma == 0 && mb == 0) return {1'b0, sa & sb, 31'd0};
    if (ma == 0) return {1'b0, sb, b[30:0]};
    if (mb == 0) return {1'b0, sa, a[30:0]};
    if (ea - eb > 30) return {1'b0, sa, a[30:0]};
    if (eb - ea > 30) return {1'b0, sb, b[30:0]};
    emin = (ea < eb) ? ea : eb;
    va  = ma <<< (ea - emin);
    vb  = mb <<< (eb - emin);
    sum = (sa ? -va : va) + (sb ? -vb : vb);
    if (sum == 0) return {1'b0, 32'd0};
    neg = sum < 0;
    mag = neg ? -sum : sum;
    p = 0;
    for (int i = 0; i < 63; i++) if (((mag >>> i) & 64'sd1) != 0) p = i;
    k = p - 23;
    if (k <= 0) begin
      q = mag <<< (-k);
    end else begin
      q    = mag >>> k;
      rem  = mag & ((64'sd1 <<< k) - 1);
      half = 64'sd1 <<< (k - 1);
      if (rem > half || (rem == half && (q & 64'sd1) != 0)) q = q + 1;
      if (q == (64'sd1 <<< 24)) begin
        q = q >>> 1;
        p = p + 1;
      end
    end
    e = emin + p - 23;
    return {1'b0, neg, e[7:0], q[22:0]};
  endfunction

  // ---------------- per-cycle model and compare ----------------
  typedef struct {
    int          id;
    logic [31:0] res;
    logic        exc;
    int          tag;
  } op_t;

  op_t         inflight[$];
  int          rr = 0;
  int          cyc = 0;
  logic [15:0] done_cnt = 16'd0;
  logic [N-1:0] acc_mask = '0;
  logic [N-1:0] exp_gnt;
  logic        exp_rv, free_m;
  int          gi;

  always @(negedge CLK) begin
    if (!RESETn) begin
      inflight.delete();
      rr = 0;
      cyc = 0;
      done_cnt = 16'd0;
      acc_mask = '0;
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_bus", {bus.rsp_id, bus.rsp_result, bus.rsp_exception}, 64'd0);
      check("rst_ops_done", 64'(ops_done), 64'd0);
    end else begin
      // an op is visible one full cycle after its grant; two in flight with no ready blocks the arbiter
      exp_rv = (inflight.size() > 0) && (inflight[0].tag <= cyc - 2);
      free_m = !(inflight.size() == 2 && !bus.rsp_ready);
      exp_gnt = '0;
      gi = -1;
      if (free_m) begin
        for (int k = 0; k < N; k++) begin
          if (gi < 0 && bus.req_valid[(rr + k) % N]) gi = (rr + k) % N;
        end
      end
      if (gi >= 0) exp_gnt[gi] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        check("rsp_id", 64'(bus.rsp_id), 64'(inflight[0].id));
        check("rsp_result", 64'(bus.rsp_result), 64'(inflight[0].res));
        check("rsp_exception", 64'(bus.rsp_exception), 64'(inflight[0].exc));
      end
      check("ops_done", 64'(ops_done), 64'(done_cnt));
      if (exp_rv && bus.rsp_ready) begin
        void'(inflight.pop_front());
        done_cnt = done_cnt + 16'd1;
      end
      if (gi >= 0) begin
        logic [32:0] r;
        r = ref_addsub(bus.req_a[32*gi +: 32], bus.req_b[32*gi +: 32], bus.req_sub[gi]);
        inflight.push_back('{id: gi, res: r[31:0], exc: r[32], tag: cyc});
        rr = (gi + 1) % N;
      end
      acc_mask = bus.req_valid & bus.req_ready;
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.req_valid[i]       = 1'b1;
    bus.req_a[32*i +: 32]  = a;
    bus.req_b[32*i +: 32]  = b;
    bus.req_sub[i]         = sub;
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  task automatic new_rand_op(input int i);
    logic [31:0] a, b;
    int r;
    a = ($urandom_range(0, 31) == 0) ? {1'($urandom_range(0, 1)), 31'd0} : rnd_fp();
    r = int'($urandom_range(0, 15));
    if (r == 0)      b = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
    else if (r == 1) b = {1'($urandom_range(0, 1)), 31'd0};
    else if (r == 2) b = a;
    else if (r <= 6) b = {1'($urandom_range(0, 1)), a[30:23], 23'($urandom)};
    else             b = rnd_fp();
    set_req(i, a, b, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] one_f [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] rr_sum[4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  int rdy_pct, vld_pct;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b0;
    RESETn        = 1'b0;

    // hand-computed pins of the reference model
    check("pin_add",      64'(ref_addsub(32'h3FC00000, 32'h40100000, 1'b0)), 64'h0_40700000);
    check("pin_sub",      64'(ref_addsub(32'h40A00000, 32'h40400000, 1'b1)), 64'h0_40000000);
    check("pin_exc",      64'(ref_addsub(32'h7F800000, 32'h3F800000, 1'b0)), 64'h1_00000000);
    check("pin_tie_even", 64'(ref_addsub(32'h3F800000, 32'h33800000, 1'b0)), 64'h0_3F800000);
    check("pin_tie_up",   64'(ref_addsub(32'h3F800001, 32'h33800000, 1'b0)), 64'h0_3F800002);
    check("pin_cancel",   64'(ref_addsub(32'h40400000, 32'h40400000, 1'b1)), 64'h0_00000000);
    check("pin_neg",      64'(ref_addsub(32'hBF800000, 32'h3F000000, 1'b0)), 64'h0_BF000000);

    repeat (2) next_cycle();
    RESETn = 1'b1;

    // single add
    bus.rsp_ready = 1'b1;
    set_req(0, 32'h3FC00000, 32'h40100000, 1'b0);
    @(negedge CLK); check("add_grant", 64'(bus.req_ready), 64'b0001);
    next_cycle(); bus.req_valid = '0;
    @(negedge CLK); check("add_not_yet", 64'(bus.rsp_valid), 64'd0);
    @(negedge CLK);
    check("add_valid", 64'(bus.rsp_valid), 64'd1);
    check("add_id", 64'(bus.rsp_id), 64'd0);
    check("add_result", 64'(bus.rsp_result), 64'h40700000);
    next_cycle();

    // subtract
    set_req(2, 32'h40A00000, 32'h40400000, 1'b1);
    @(negedge CLK); check("sub_grant", 64'(bus.req_ready), 64'b0100);
    next_cycle(); bus.req_valid = '0;
    @(negedge CLK); @(negedge CLK);
    check("sub_id", 64'(bus.rsp_id), 64'd2);
    check("sub_result", 64'(bus.rsp_result), 64'h40000000);
    next_cycle();

    // exception
    set_req(3, 32'h7F800000, 32'h3F800000, 1'b0);
    next_cycle(); bus.req_valid = '0;
    @(negedge CLK); @(negedge CLK);
    check("exc_flag", 64'(bus.rsp_exception), 64'd1);
    check("exc_result", 64'(bus.rsp_result), 64'd0);
    next_cycle();
    @(negedge CLK); check("ops_after_three", 64'(ops_done), 64'd3);
    next_cycle();

    // reset with both stages full
    bus.rsp_ready = 1'b0;
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_req(1, 32'h40400000, 32'h3F800000, 1'b0);
    next_cycle(); bus.req_valid[0] = 1'b0;
    next_cycle(); bus.req_valid[1] = 1'b0;
    set_req(1, 32'h40000000, 32'h3F800000, 1'b0);
    set_req(3, 32'h40000000, 32'h3F800000, 1'b1);
    #1 RESETn = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_ops_done", 64'(ops_done), 64'd0);
    @(negedge CLK);
    next_cycle();
    RESETn = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge CLK); check("post_rst_first_grant", 64'(bus.req_ready), 64'b0010);
    next_cycle(); bus.req_valid[1] = 1'b0;
    next_cycle(); bus.req_valid[3] = 1'b0;
    repeat (3) next_cycle();

    // round-robin from reset with every requester valid
    RESETn = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, one_f[i], 32'h3F800000, 1'b0);
    bus.rsp_ready = 1'b1;
    repeat (2) next_cycle();
    RESETn = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge CLK);
      check("rr_grant", 64'(bus.req_ready), 64'(1 << (n % 4)));
      if (n >= 2) begin
        check("rr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rr_rsp_id", 64'(bus.rsp_id), 64'((n - 2) % 4));
        check("rr_rsp_result", 64'(bus.rsp_result), 64'(rr_sum[(n - 2) % 4]));
      end
      next_cycle();
    end
    bus.req_valid = '0;
    repeat (3) next_cycle();

    // backpressure
    RESETn = 1'b0;
    bus.rsp_ready = 1'b0;
    next_cycle();
    RESETn = 1'b1;
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_req(1, 32'h40400000, 32'h3F800000, 1'b0);
    @(negedge CLK); check("bp_grant0", 64'(bus.req_ready), 64'b0001);
    next_cycle(); bus.req_valid[0] = 1'b0;
    @(negedge CLK); check("bp_grant1", 64'(bus.req_ready), 64'b0010);
    next_cycle(); bus.req_valid[1] = 1'b0;
    set_req(2, 32'h40000000, 32'h40000000, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_hold_id", 64'(bus.rsp_id), 64'd0);
      check("bp_hold_result", 64'(bus.rsp_result), 64'h40000000);
      check("bp_no_grant", 64'(bus.req_ready), 64'd0);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    @(negedge CLK); check("bp_first_id", 64'(bus.rsp_id), 64'd0);
    next_cycle();
    @(negedge CLK);
    check("bp_second_id", 64'(bus.rsp_id), 64'd1);
    check("bp_second_result", 64'(bus.rsp_result), 64'h40800000);
    next_cycle();
    @(negedge CLK);
    check("bp_drained", 64'(bus.rsp_valid), 64'd0);
    check("bp_ops_done", 64'(ops_done), 64'd2);
    next_cycle();

    // randomized traffic, checked by the per-cycle model
    rdy_pct = 70;
    vld_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) begin
        rdy_pct = int'($urandom_range(20, 100));
        vld_pct = int'($urandom_range(10, 100));
      end
      if (c == 2100) begin
        RESETn = 1'b0;
        next_cycle();
        RESETn = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && int'($urandom_range(0, 99)) < vld_pct) new_rand_op(i);
      end
      bus.rsp_ready = int'($urandom_range(0, 99)) < rdy_pct;
      next_cycle();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (5) next_cycle();
    @(negedge CLK);
    check("final_idle", 64'(bus.rsp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Shares one FPU IEEE-754 single-precision add/subtract unit between `N_REQ` requesters, such as neuron update engines or the CPU core FPU port. A round-robin arbiter grants at most one request per cycle. The block then registers operands into a 2-stage pipeline around the combinational add/sub unit and returns each result on a shared response bus tagged with the requester ID. Full throughput is one operation per cycle, with backpressure from the response consumer.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: requester ID width, equal to clog2(`N_REQ`).
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESETn` in 1: reset, asynchronous and active-low.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: per-requester grant; the transfer happens on `req_valid[i] & req_ready[i]`.
- `req_a` in 32*`N_REQ`: operand A. Requester i uses bits [32i+31:32i].
- `req_b` in 32*`N_REQ`: operand B, same packing as `req_a`.
- `req_sub` in `N_REQ`: 1 selects subtract (A−B), 0 selects add.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `ID_W`: index of the requester that issued the operation.
- `rsp_result` out 32: IEEE-754 result.
- `rsp_exception` out 1: exception flag from the add/sub unit (an operand exponent is 255).
- `ops_done` out 16: count of completed responses, wrapping.

## Operation
- Stage S1 (operand register): `s1_valid`, `s1_id`, `s1_a`, `s1_b`, `s1_sub`. The add/sub unit is fed combinationally from S1.
- Stage S2 (result register): `s2_valid`, `s2_id`, `s2_result`, `s2_exc`. These drive `rsp_*` directly.
- Advance rules:
  - `s2_adv = !s2_valid | rsp_ready`
  - `s1_adv = s1_valid & s2_adv`
  - `s1_free = !s1_valid | s2_adv`
- Arbiter:
  - When `s1_free`, grant the first i with `req_valid[i]`, searching from `rr_ptr` upward and wrapping at `N_REQ`.
  - `req_ready` is one-hot or zero, and is combinational from `req_valid`, `rr_ptr` and `s1_free`.
  - `req_ready[i]` never asserts without `req_valid[i]`.
- On a grant to index g:
  - S1 loads the operands and ID g; `s1_valid`=1.
  - `rr_ptr` ← (g+1) mod `N_REQ`.
  - With no grant, `rr_ptr` holds.
- If `s1_adv` and there is no grant, `s1_valid` ← 0.
- On `s1_adv`, S2 captures the unit output and `s1_id`; `s2_valid`=1.
- If `s2_adv` and `!s1_adv`, then `s2_valid` ← 0.
- `ops_done` increments by 1 on each `rsp_valid & rsp_ready` and wraps from 0xFFFF to 0.
- Responses return in grant order. No reordering, no dropping.
- Exception passes straight through: result 0x00000000 with `rsp_exception`=1.
- While `rsp_valid`=1 and `rsp_ready`=0, all `rsp_*` outputs hold stable.

## Timing
- Reset (async assert, sync release):
  - `s1_valid`, `s2_valid` = 0
  - `rr_ptr` = 0
  - `ops_done` = 0
  - `rsp_id`, `rsp_result`, `rsp_exception` = 0
  - `req_ready` = 0 while `RESETn` is low
- Latency: a grant at edge k gives `rsp_valid`=1 after edge k+1, so the response is accepted no earlier than edge k+2.
- Throughput: one operation per cycle while `rsp_ready`=1.
- Maximum in flight is 2. When both stages are full and `rsp_ready`=0, `req_ready`=0 for all requesters.
- When `rsp_ready` rises with both stages full, a new grant occurs in the same cycle: S2 drains, S1 moves to S2, and a new request enters S1.
- A requester with `req_valid` held high waits at most `N_REQ`−1 grants to other requesters.
- Mid-operation reset: the in-flight operations are discarded with no response, and the arbiter restarts at index 0.

## Test plan
- **Single add.** Req0: A=0x3FC00000, B=0x40100000, sub=0, `rsp_ready`=1, grant at edge k. Required: after edge k+1, `rsp_valid`=1, id=0, result=0x40700000 (3.75).
- **Subtract.** Req2: A=0x40A00000, B=0x40400000, sub=1. Required: result=0x40000000 (2.0), id=2.
- **Round-robin.** All 4 requesters valid continuously from reset, `rsp_ready`=1. Required: grant order 0,1,2,3,0; responses arrive back-to-back in the same ID order, one per cycle.
- **Backpressure.** Issue two ops, then hold `rsp_ready`=0 for 3 cycles. Required: the response is stable, `req_ready`=0, and no third grant. After release, both responses come out in order and `ops_done`=2.
- **Exception.** A=0x7F800000, B=0x3F800000. Required: `rsp_exception`=1, result=0x00000000.
- **Reset mid-flight.** Assert `RESETn`=0 with both stages full. Required: `rsp_valid`=0 immediately and `ops_done`=0. After release, the first grant goes to the lowest valid index.
